// File: rtl/red_track_pkg.sv
// Shared constants and types for the red-blob centroid tracker.
package red_track_pkg;
  localparam logic [9:0]  H_RES    = 10'd640;
  localparam logic [9:0]  V_RES    = 10'd480;
  localparam logic [15:0] CENTER_X = 16'd319;
  localparam logic [15:0] CENTER_Y = 16'd239;
  localparam int          SUM_W    = 28;
  localparam int          CNT_W    = 19;

  localparam logic [4:0]       R_MIN      = 5'd20;
  localparam logic [5:0]       G_MAX      = 6'd20;
  localparam logic [4:0]       B_MAX      = 5'd12;
  localparam logic [CNT_W-1:0] MIN_PIXELS = CNT_W'(64);

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {IDLE, DIV, DONE} centroid_state_t;
endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; o_done pulses after N_W steps.
module seq_divider #(
  parameter int N_W = 28,
  parameter int D_W = 19
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [N_W-1:0] i_dividend,
  input  logic [D_W-1:0] i_divisor,
  output logic [N_W-1:0] o_quotient,
  output logic           o_done
);
  localparam int             C_W  = $clog2(N_W);
  localparam logic [C_W-1:0] LAST = C_W'(N_W - 1);

  logic [N_W-1:0] r_q;
  logic [D_W-1:0] r_rem;
  logic [D_W-1:0] r_div;
  logic [C_W-1:0] r_cnt;
  logic           r_run;
  logic           r_done;
  logic [D_W:0]   w_rs;
  logic [D_W+1:0] w_sub;

  // Dividend shifts out of r_q MSB-first while quotient bits shift in at the bottom.
  assign w_rs  = {r_rem, r_q[N_W-1]};
  assign w_sub = {1'b0, w_rs} - {2'b00, r_div};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_q   <= i_dividend;
        r_rem <= '0;
        r_div <= i_divisor;
        r_cnt <= '0;
        r_run <= 1'b1;
      end else if (r_run) begin
        r_q   <= {r_q[N_W-2:0], ~w_sub[D_W+1]};
        r_rem <= w_sub[D_W+1] ? w_rs[D_W-1:0] : w_sub[D_W-1:0];
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_quotient = r_q;
  assign o_done     = r_done;
endmodule

// File: rtl/red_centroid_detect.sv
// Per-frame red-pixel centroid: classify, accumulate, divide at frame end, hold result.
module red_centroid_detect
  import red_track_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        pix_valid,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  input  logic [15:0] rgb565,
  output logic [15:0] x_meas,
  output logic [15:0] y_meas,
  output logic        red_detect,
  output logic        meas_valid,
  output logic        busy
);
  rgb565_t          w_px;
  logic             w_red;
  logic [SUM_W-1:0] w_add_x, w_add_y, w_sum_x, w_sum_y, w_lat_x, w_lat_y;
  logic [CNT_W-1:0] w_add_c, w_cnt, w_lat_c;
  logic [SUM_W-1:0] r_sum_x, r_sum_y;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] w_qx, w_qy;
  logic             w_done_x, w_done_y, w_start, w_big;
  logic             w_unused_q;
  centroid_state_t  r_state;
  logic             r_blob;

  assign w_px  = rgb565_t'(rgb565);
  assign w_red = pix_valid & (x_pixel < H_RES) & (y_pixel < V_RES) &
                 (w_px.r >= R_MIN) & (w_px.g <= G_MAX) & (w_px.b <= B_MAX);

  assign w_add_x = w_red ? {{(SUM_W-10){1'b0}}, x_pixel} : '0;
  assign w_add_y = w_red ? {{(SUM_W-10){1'b0}}, y_pixel} : '0;
  assign w_add_c = {{(CNT_W-1){1'b0}}, w_red};
  assign w_sum_x = r_sum_x + w_add_x;
  assign w_sum_y = r_sum_y + w_add_y;
  assign w_cnt   = r_cnt + w_add_c;

  // With a coincident frame_start the current pixel opens the new frame instead.
  assign w_lat_x = frame_start ? r_sum_x : w_sum_x;
  assign w_lat_y = frame_start ? r_sum_y : w_sum_y;
  assign w_lat_c = frame_start ? r_cnt   : w_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else if (frame_start) begin
      r_sum_x <= w_add_x;
      r_sum_y <= w_add_y;
      r_cnt   <= w_add_c;
    end else if (frame_end) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else begin
      r_sum_x <= w_sum_x;
      r_sum_y <= w_sum_y;
      r_cnt   <= w_cnt;
    end
  end

  // Frame results arriving outside IDLE are dropped.
  assign w_big   = (w_lat_c >= MIN_PIXELS);
  assign w_start = frame_end & (r_state == IDLE) & w_big;

  seq_divider #(.N_W(SUM_W), .D_W(CNT_W)) u_div_x (
    .clk(clk), .rst(reset), .i_start(w_start), .i_dividend(w_lat_x),
    .i_divisor(w_lat_c), .o_quotient(w_qx), .o_done(w_done_x)
  );
  seq_divider #(.N_W(SUM_W), .D_W(CNT_W)) u_div_y (
    .clk(clk), .rst(reset), .i_start(w_start), .i_dividend(w_lat_y),
    .i_divisor(w_lat_c), .o_quotient(w_qy), .o_done(w_done_y)
  );

  assign w_unused_q = ^{w_qx[SUM_W-1:16], w_qy[SUM_W-1:16]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_blob     <= 1'b0;
      x_meas     <= CENTER_X;
      y_meas     <= CENTER_Y;
      red_detect <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (r_state)
        IDLE: if (frame_end) begin
          r_blob  <= w_big;
          r_state <= w_big ? DIV : DONE;
        end
        DIV: if (w_done_x & w_done_y) r_state <= DONE;
        DONE: begin
          meas_valid <= 1'b1;
          red_detect <= r_blob;
          if (r_blob) begin
            x_meas <= w_qx[15:0];
            y_meas <= w_qy[15:0];
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == DIV);
endmodule

// File: tb/tb_red_centroid_detect.sv
// Directed bench for red_centroid_detect with hand-computed centroids and latencies.
module tb_red_centroid_detect;
  logic        clk, reset, frame_start, frame_end, pix_valid;
  logic [9:0]  x_pixel, y_pixel;
  logic [15:0] rgb565, x_meas, y_meas;
  logic        red_detect, meas_valid, busy;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, mv_cnt = 0, mv_cyc = -1000, fe_cyc = 0, base = 0;

  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] R20   = 16'hA000;
  localparam logic [15:0] R19   = 16'h9800;

  red_centroid_detect dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .x_pixel(x_pixel), .y_pixel(y_pixel), .rgb565(rgb565),
    .x_meas(x_meas), .y_meas(y_meas), .red_detect(red_detect),
    .meas_valid(meas_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input logic fs, input logic fe, input logic pv,
                      input int x, input int y, input logic [15:0] c);
    frame_start = fs; frame_end = fe; pix_valid = pv;
    x_pixel = 10'(x); y_pixel = 10'(y); rgb565 = c;
    @(posedge clk); #1;
    cyc++;
    if (meas_valid) begin
      mv_cnt++;
      mv_cyc = cyc;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0, 0, 16'h0000);
  endtask

  task automatic pix(input int x, input int y, input logic [15:0] c);
    step(1'b0, 1'b0, 1'b1, x, y, c);
  endtask

  task automatic block(input int x0, input int y0, input int w, input int h,
                       input logic [15:0] c);
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++)
        pix(x0 + i, y0 + j, c);
  endtask

  task automatic fend();
    step(1'b0, 1'b1, 1'b0, 0, 0, 16'h0000);
    fe_cyc = cyc;
    base   = mv_cnt;
  endtask

  task automatic wait_mv(input string tag, input int exp_lat);
    while (mv_cnt == base && (cyc - fe_cyc) < 40) idle();
    check(tag, mv_cyc - fe_cyc, exp_lat);
  endtask

  task automatic fstart();
    step(1'b1, 1'b0, 1'b0, 0, 0, 16'h0000);
  endtask

  initial begin
    reset = 1'b1; frame_start = 0; frame_end = 0; pix_valid = 0;
    x_pixel = 0; y_pixel = 0; rgb565 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", x_meas, 319);
    check("rst_y", y_meas, 239);
    check("rst_det", red_detect, 0);
    check("rst_mv", meas_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    idle();

    // 10x10 blob: x mean 104.5 -> 104, y mean 204.5 -> 204
    fstart();
    block(90, 195, 30, 5, WHITE);
    block(100, 200, 10, 10, RED);
    block(90, 215, 30, 2, WHITE);
    fend();
    check("blob_busy", busy, 1);
    wait_mv("blob_lat", 30);
    check("blob_det", red_detect, 1);
    check("blob_x", x_meas, 104);
    check("blob_y", y_meas, 204);
    check("blob_busy_done", busy, 0);
    idle();
    check("blob_mv_pulse", meas_valid, 0);

    // 25 pixels: below threshold, position held
    fstart();
    block(10, 10, 5, 5, RED);
    fend();
    wait_mv("small_lat", 1);
    check("small_det", red_detect, 0);
    check("small_x", x_meas, 104);
    check("small_y", y_meas, 204);
    check("small_busy", busy, 0);

    // R=20 counted: 8x8 at origin -> 3.5 -> 3
    fstart();
    block(0, 0, 8, 8, R20);
    fend();
    wait_mv("r20_lat", 30);
    check("r20_det", red_detect, 1);
    check("r20_x", x_meas, 3);
    check("r20_y", y_meas, 3);

    // R=19 not counted
    fstart();
    block(0, 0, 8, 8, R19);
    fend();
    wait_mv("r19_lat", 1);
    check("r19_det", red_detect, 0);
    check("r19_x", x_meas, 3);

    // 63 good + G=21 + x=640 + y=480 -> count 63
    fstart();
    block(0, 0, 8, 7, R20);
    block(0, 7, 7, 1, R20);
    pix(7, 7, {5'd31, 6'd21, 5'd0});
    pix(640, 7, RED);
    pix(5, 480, RED);
    fend();
    wait_mv("g21_lat", 1);
    check("g21_det", red_detect, 0);

    // 63 good + G=20,B=12 boundary pixel -> count 64
    fstart();
    block(0, 0, 8, 7, R20);
    block(0, 7, 7, 1, R20);
    pix(7, 7, {5'd20, 6'd20, 5'd12});
    fend();
    wait_mv("g20_lat", 30);
    check("g20_det", red_detect, 1);
    check("g20_x", x_meas, 3);

    // Edge pixels: stray pixels before frame_start must be cleared;
    // (0,0)+(639,479)+62 -> sx=20169, sy=6710, cnt=64 -> 315, 104
    block(600, 400, 5, 1, RED);
    step(1'b1, 1'b0, 1'b1, 0, 0, RED);
    block(300, 100, 31, 2, RED);
    step(1'b0, 1'b1, 1'b1, 639, 479, RED);
    fe_cyc = cyc;
    base   = mv_cnt;
    wait_mv("edge_lat", 30);
    check("edge_det", red_detect, 1);
    check("edge_x", x_meas, 315);
    check("edge_y", y_meas, 104);

    // Second frame_end 10 cycles into DIV is discarded
    fstart();
    block(100, 200, 10, 10, RED);
    fend();
    step(1'b1, 1'b0, 1'b1, 0, 0, RED);
    for (int i = 1; i < 8; i++) pix(i, 0, RED);
    idle();
    check("dbl_busy", busy, 1);
    step(1'b0, 1'b1, 1'b0, 0, 0, 16'h0000);
    wait_mv("dbl_lat", 30);
    check("dbl_det", red_detect, 1);
    check("dbl_x", x_meas, 104);
    check("dbl_y", y_meas, 204);
    repeat (40) idle();
    check("dbl_pulses", mv_cnt - base, 1);

    // Reset 15 cycles into DIV
    fstart();
    block(0, 0, 8, 8, R20);
    fend();
    repeat (15) idle();
    check("rdiv_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("rdiv_x", x_meas, 319);
    check("rdiv_y", y_meas, 239);
    check("rdiv_det", red_detect, 0);
    check("rdiv_busy0", busy, 0);
    check("rdiv_mv", meas_valid, 0);
    repeat (3) idle();
    reset = 1'b0;
    repeat (40) idle();
    check("rdiv_no_mv", mv_cnt - base, 0);
    check("rdiv_x_hold", x_meas, 319);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
